// File: rtl/pool_writeback.sv
// Purpose : saturates a row-major N x N accumulator stream to 8 bits, applies 2x2
//           pooling (max, or average when AVG_POOL_EN is defined), packs four pooled
//           bytes per 32-bit word and writes the words to memory port C from BASE_ADDR.
// Latency : last input beat -> first write 1 cycle; last write -> done 1 cycle
//           (18 cycles start-to-done for N=4 at full input rate).
// Backpr. : in_ready is high only in COLLECT; in_valid low stalls with no timeout.
// Ports   : clk/rst (async active-high), start pulse, in_valid/in_ready/in_data/in_last
//           element stream, mem_en_write_C/mem_addr_C/mem_data_C registered write port,
//           busy, done pulse, sticky protocol_err.
// Config  : `define AVG_POOL_EN selects average pooling; default build is max pooling.
module pool_writeback #(
    parameter int                MAT_N     = 4,
    parameter int                ACC_W     = 20,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_data,
    input  logic              in_last,
    output logic              mem_en_write_C,
    output logic [ADDR_W-1:0] mem_addr_C,
    output logic [31:0]       mem_data_C,
    output logic              busy,
    output logic              done,
    output logic              protocol_err
);
    localparam int NP     = (MAT_N / 2) * (MAT_N / 2);   // number of pooled outputs
    localparam int NW     = NP / 4;                       // number of memory words
    localparam int CNT_W  = $clog2(MAT_N * MAT_N);
    localparam int PIDX_W = $clog2(NP);
    localparam int WR_W   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(MAT_N * MAT_N - 1);
    localparam logic [WR_W-1:0]  WR_LAST = WR_W'(NW - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WR_W-1:0]     wr_q, wr_d;
    logic                err_q, err_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [NP-1:0][7:0]  bytes_d;
    logic [7:0]          sat;
    logic [PIDX_W-1:0]   pidx;
    logic                last_beat;
`ifdef AVG_POOL_EN
    logic [NP-1:0][9:0]  sum_q, sum_d;   // 4 x 255 = 1020 fits in 10 bits
`else
    logic [NP-1:0][7:0]  pool_q, pool_d;
`endif

    assign sat       = (in_data > ACC_W'(255)) ? 8'hFF : in_data[7:0];
    assign last_beat = (cnt_q == LAST_K);
    // k -> (row/2)*(N/2) + col/2
    assign pidx = PIDX_W'((int'(cnt_q) / MAT_N / 2) * (MAT_N / 2) + (int'(cnt_q) % MAT_N) / 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        wen_d   = 1'b0;
`ifdef AVG_POOL_EN
        sum_d   = sum_q;
`else
        pool_d  = pool_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef AVG_POOL_EN
                    sum_d   = '0;
`else
                    pool_d  = '0;
`endif
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
`ifdef AVG_POOL_EN
                    sum_d[pidx] = sum_q[pidx] + {2'b00, sat};
`else
                    if (sat > pool_q[pidx]) pool_d[pidx] = sat;
`endif
                    // in_last must coincide exactly with the final element
                    if (in_last != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = WRITE;
                        wr_d    = '0;
                        wen_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                // wr_q names the word currently on the port
                if (wr_q == WR_LAST) begin
                    state_d = DONE;
                end else begin
                    wr_d  = wr_q + 1'b1;
                    wen_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Words are built from next-state pool values so the final beat's
    // contribution is already included in the first registered write.
    always_comb begin
`ifdef AVG_POOL_EN
        for (int p = 0; p < NP; p++) bytes_d[p] = sum_d[p][9:2];
`else
        bytes_d = pool_d;
`endif
        addr_d = '0;
        data_d = '0;
        if (wen_d) begin
            addr_d = BASE_ADDR + ADDR_W'(wr_d);
            for (int w = 0; w < NW; w++) begin
                if (wr_d == WR_W'(w)) data_d = bytes_d[w*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef AVG_POOL_EN
            sum_q   <= '0;
`else
            pool_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef AVG_POOL_EN
            sum_q   <= sum_d;
`else
            pool_q  <= pool_d;
`endif
        end
    end

    assign in_ready       = (state_q == COLLECT);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign protocol_err   = err_q;
    assign mem_en_write_C = wen_q;
    assign mem_addr_C     = addr_q;
    assign mem_data_C     = data_q;

endmodule

// File: tb/tb_pool_writeback.sv
// Purpose : scoreboard bench for pool_writeback (N=4); expected write words are queued
//           by the stimulus and popped by an independent negedge monitor.
`timescale 1ns/1ps
module tb_pool_writeback;
    localparam int ACC_W  = 20;
    localparam int ADDR_W = 10;
`ifdef AVG_POOL_EN
    localparam logic [31:0] EXP_BASE = 32'h7D692D19;  // 25, 45, 105, 125
    localparam logic [31:0] EXP_SAT  = 32'h97692D19;  // last sum 100+110+140+255=605 -> 151
`else
    localparam logic [31:0] EXP_BASE = 32'h96824632;  // 50, 70, 130, 150
    localparam logic [31:0] EXP_SAT  = 32'hFF824632;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ACC_W-1:0]  in_data = '0;
    logic              in_last = 1'b0;
    logic              mem_en_write_C;
    logic [ADDR_W-1:0] mem_addr_C;
    logic [31:0]       mem_data_C;
    logic              busy, done, protocol_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int last_wr_cyc = -100;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t exp_q[$];
    logic [ACC_W-1:0] stim [16];

    pool_writeback dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_en_write_C(mem_en_write_C), .mem_addr_C(mem_addr_C), .mem_data_C(mem_data_C),
        .busy(busy), .done(done), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every write, idle-port zero check, done spacing.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en_write_C) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                             mem_addr_C, mem_data_C);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr_C), 32'(e.addr));
                    check("wr_data", mem_data_C, e.data);
                end
            end else begin
                check("idle_addr", 32'(mem_addr_C), 32'd0);
                check("idle_data", mem_data_C, 32'd0);
            end
            if (done) begin
                done_cnt++;
                check("done_after_write", 32'(cyc - last_wr_cyc), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int nbeats, input int last_k, input bit gappy, input int start_at);
        for (int k = 0; k < nbeats; k++) begin
            if (gappy) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                start    = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = stim[k];
            in_last  = (k == last_k);
            start    = (k == start_at);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string name, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 60 && dcyc < 0; i++) begin
            if (done) dcyc = cyc;
            else step();
        end
        if (dcyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: done not seen within 60 cycles, expected a pulse", name);
        end
    endtask

    task automatic run_frame(input string name, input logic [31:0] exp_data, input int last_k,
                             input bit gappy, input int start_at, input bit exp_err,
                             input bit start_on_done);
        int w0, d0, s0, dcyc;
        w0 = wr_cnt;
        d0 = done_cnt;
        exp_q.push_back(wr_t'{10'h200, exp_data});
        s0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy), 32'd1);
        check({name, "_err_cleared"}, 32'(protocol_err), 32'd0);
        send_beats(16, last_k, gappy, start_at);
        wait_done(name, dcyc);
        if (!gappy && dcyc >= 0) check({name, "_start_to_done"}, 32'(dcyc - s0), 32'd18);
        start = start_on_done;   // a start during done must be ignored
        step();
        start = 1'b0;
        check({name, "_busy_after_done"}, 32'(busy), 32'd0);
        check({name, "_protocol_err"}, 32'(protocol_err), 32'(exp_err));
        step();
        check({name, "_still_idle"}, 32'(busy), 32'd0);
        check({name, "_write_count"}, 32'(wr_cnt - w0), 32'd1);
        check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int w0, d0;
        for (int k = 0; k < 16; k++) stim[k] = ACC_W'(10 * k);
        step();
        step();
        // reset state
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(protocol_err), 32'd0);
        check("rst_wen", 32'(mem_en_write_C), 32'd0);
        check("rst_addr", 32'(mem_addr_C), 32'd0);
        check("rst_data", mem_data_C, 32'd0);
        rst = 1'b0;
        step();

        // in_valid/in_last in IDLE are ignored
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 20'd999;
        step();
        step();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_err", 32'(protocol_err), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        step();

        run_frame("base", EXP_BASE, 15, 1'b0, -1, 1'b0, 1'b0);

        stim[15] = ACC_W'(300);
        run_frame("sat", EXP_SAT, 15, 1'b0, -1, 1'b0, 1'b1);
        stim[15] = ACC_W'(150);

        run_frame("gappy_restart", EXP_BASE, 15, 1'b1, 5, 1'b0, 1'b0);

        // reset mid-frame after 8 beats
        w0 = wr_cnt;
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        send_beats(8, 99, 1'b0, -1);
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_wen", 32'(mem_en_write_C), 32'd0);
        check("abort_addr", 32'(mem_addr_C), 32'd0);
        check("abort_data", mem_data_C, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_frame("after_rst", EXP_BASE, 15, 1'b0, -1, 1'b0, 1'b0);

        run_frame("last_early", EXP_BASE, 7, 1'b0, -1, 1'b1, 1'b0);
        run_frame("err_clear", EXP_BASE, 15, 1'b0, -1, 1'b0, 1'b0);

        repeat (5) step();
        check("expected_writes_consumed", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
